// File: rtl/rect_painter.sv
// Rectangle rasteriser for the VGA pixel-write path: walks a W x H box in raster
// order, one pixel per clock, as a solid fill or a 1-pixel outline.
module rect_painter #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int SIZE_W   = 5,
  parameter int COLOUR_W = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                abort,
  input  logic [X_W-1:0]      x0,
  input  logic [Y_W-1:0]      y0,
  input  logic [SIZE_W-1:0]   width,
  input  logic [SIZE_W-1:0]   height,
  input  logic [COLOUR_W-1:0] colour_in,
  input  logic                mode,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_DRAW,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  // Operation parameters captured when a request is accepted.
  logic [X_W-1:0]      x0_q;
  logic [Y_W-1:0]      y0_q;
  logic [SIZE_W-1:0]   w_q, h_q;
  logic [COLOUR_W-1:0] lat_colour_q;
  logic                mode_q;

  logic [SIZE_W-1:0]   col_q, col_d;
  logic [SIZE_W-1:0]   row_q, row_d;

  logic [X_W-1:0]      x_q, x_d;
  logic [Y_W-1:0]      y_q, y_d;
  logic [COLOUR_W-1:0] colour_q, colour_d;
  logic                plot_q, plot_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic last_col, last_row, size_zero, on_edge;

  assign last_col  = (col_q == w_q - SIZE_W'(1));
  assign last_row  = (row_q == h_q - SIZE_W'(1));
  assign size_zero = (w_q == '0) || (h_q == '0);

  // State, counters, captured parameters and registered outputs.
  // NOTE: every register here uses <= so all of them update from the same
  // pre-edge values; a blocking = would let later lines see half-updated state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      x0_q         <= '0;
      y0_q         <= '0;
      w_q          <= '0;
      h_q          <= '0;
      lat_colour_q <= '0;
      mode_q       <= 1'b0;
      col_q        <= '0;
      row_q        <= '0;
      x_q          <= '0;
      y_q          <= '0;
      colour_q     <= '0;
      plot_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      if (state_q == S_IDLE && start) begin
        x0_q         <= x0;
        y0_q         <= y0;
        w_q          <= width;
        h_q          <= height;
        lat_colour_q <= colour_in;
        mode_q       <= mode;
      end
    end
  end

  // Next-state logic. abort only matters in the two active states.
  // NOTE: each always_comb assigns a default to every output first, so no
  // path through the case leaves a signal unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_SETUP;
      S_SETUP: begin
        if (abort)          state_d = S_IDLE;
        else if (size_zero) state_d = S_DONE;
        else                state_d = S_DRAW;
      end
      S_DRAW: begin
        if (abort)                     state_d = S_IDLE;
        else if (last_col && last_row) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Scan counters: (col_d, row_d) is the pixel presented after the next edge.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (state_q == S_SETUP) begin
      col_d = '0;
      row_d = '0;
    end else if (state_q == S_DRAW && state_d == S_DRAW) begin
      if (last_col) begin
        col_d = '0;
        row_d = row_q + SIZE_W'(1);
      end else begin
        col_d = col_q + SIZE_W'(1);
      end
    end
  end

  assign on_edge = (col_d == '0) || (col_d == w_q - SIZE_W'(1)) ||
                   (row_d == '0) || (row_d == h_q - SIZE_W'(1));

  // Output logic: coordinates wrap silently; outside DRAW they hold.
  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    plot_d   = 1'b0;
    busy_d   = (state_d == S_SETUP) || (state_d == S_DRAW);
    done_d   = (state_d == S_DONE);
    if (state_d == S_DRAW) begin
      x_d      = x0_q + X_W'(col_d);
      y_d      = y0_q + Y_W'(row_d);
      colour_d = lat_colour_q;
      plot_d   = !mode_q || on_edge;
    end
  end

  assign x      = x_q;
  assign y      = y_q;
  assign colour = colour_q;
  assign plot   = plot_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_rect_painter.sv
// Directed bench for rect_painter: a table of rectangles with hand-computed
// totals, a per-pixel raster model, and sequences for abort/reset/restart.
module tb_rect_painter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start, abort;
  logic [7:0] x0;
  logic [6:0] y0;
  logic [4:0] width, height;
  logic [2:0] colour_in;
  logic       mode;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, busy, done;

  int n_vec  = 0;
  int n_fail = 0;

  rect_painter #(.X_W(8), .Y_W(7), .SIZE_W(5), .COLOUR_W(3)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .abort     (abort),
    .x0        (x0),
    .y0        (y0),
    .width     (width),
    .height    (height),
    .colour_in (colour_in),
    .mode      (mode),
    .x         (x),
    .y         (y),
    .colour    (colour),
    .plot      (plot),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] x0;
    logic [6:0] y0;
    logic [4:0] w;
    logic [4:0] h;
    logic [2:0] col;
    logic       mode;
    int         exp_plots;
    int         exp_busy;
    int         fx, fy, lx, ly;   // first / last plotted pixel
    bit         restart;          // re-pulse start during DRAW
    bit         start_in_done;    // hold start during the DONE cycle
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int  k, n, w, h, plots, busy_n, done_k;
    int  fx, fy, lx, ly;
    bit  seen;
    w = int'(v.w);
    h = int'(v.h);
    n = w * h;
    plots = 0; busy_n = 0; done_k = -1; seen = 0;
    fx = -1; fy = -1; lx = -1; ly = -1;
    x0 = v.x0; y0 = v.y0; width = v.w; height = v.h;
    colour_in = v.col; mode = v.mode; start = 1'b1;
    step();
    // Scramble inputs: the operation must use the values captured at E0.
    start = 1'b0; x0 = ~v.x0; y0 = ~v.y0; width = ~v.w; height = ~v.h;
    colour_in = ~v.col; mode = ~v.mode;
    k = 1;
    while (done_k < 0 && k < 600) begin
      if (busy) busy_n++;
      if (plot) begin
        plots++;
        if (!seen) begin fx = int'(x); fy = int'(y); seen = 1; end
        lx = int'(x); ly = int'(y);
      end
      if (k == 1) begin
        check($sformatf("v%0d setup_busy", idx), int'(busy), 1);
        check($sformatf("v%0d setup_plot", idx), int'(plot), 0);
      end
      if (k >= 2 && k < n + 2) begin
        int i, c, r;
        bit ep;
        i  = k - 2;
        c  = i % w;
        r  = i / w;
        ep = (v.mode == 1'b0) || c == 0 || c == w - 1 || r == 0 || r == h - 1;
        check($sformatf("v%0d px%0d x", idx, i), int'(x), (int'(v.x0) + c) % 256);
        check($sformatf("v%0d px%0d y", idx, i), int'(y), (int'(v.y0) + r) % 128);
        check($sformatf("v%0d px%0d plot", idx, i), int'(plot), int'(ep));
        check($sformatf("v%0d px%0d colour", idx, i), int'(colour), int'(v.col));
      end
      if (done) done_k = k;
      start = v.restart && (k == 4);
      if (done_k < 0) begin
        step();
        k++;
      end
    end
    check($sformatf("v%0d done_latency", idx), done_k, n + 2);
    check($sformatf("v%0d plots", idx), plots, v.exp_plots);
    check($sformatf("v%0d busy_cycles", idx), busy_n, v.exp_busy);
    check($sformatf("v%0d done_busy", idx), int'(busy), 0);
    check($sformatf("v%0d done_plot", idx), int'(plot), 0);
    if (v.exp_plots > 0) begin
      check($sformatf("v%0d first_x", idx), fx, v.fx);
      check($sformatf("v%0d first_y", idx), fy, v.fy);
      check($sformatf("v%0d last_x", idx), lx, v.lx);
      check($sformatf("v%0d last_y", idx), ly, v.ly);
      check($sformatf("v%0d hold_x", idx), int'(x), v.lx);
      check($sformatf("v%0d hold_y", idx), int'(y), v.ly);
    end
    start = v.start_in_done;
    step();
    start = 1'b0;
    check($sformatf("v%0d done_pulse_end", idx), int'(done), 0);
    check($sformatf("v%0d idle_busy", idx), int'(busy), 0);
    step();
    check($sformatf("v%0d idle2_busy", idx), int'(busy), 0);
  endtask

  vec_t vecs[8];

  initial begin
    //          x0     y0     w      h      col    mode plots busy fx   fy   lx   ly  rs  sd
    vecs[0] = '{8'd10, 7'd20, 5'd4,  5'd3,  3'b101, 1'b0, 12, 13, 10,  20,  13,  22, 0, 0};
    vecs[1] = '{8'd30, 7'd40, 5'd4,  5'd4,  3'b010, 1'b1, 12, 17, 30,  40,  33,  43, 0, 0};
    vecs[2] = '{8'd7,  7'd9,  5'd0,  5'd5,  3'b111, 1'b0, 0,  1,  0,   0,   0,   0,  0, 0};
    vecs[3] = '{8'd254,7'd126,5'd3,  5'd3,  3'b111, 1'b0, 9,  10, 254, 126, 0,   0,  0, 1};
    vecs[4] = '{8'd5,  7'd5,  5'd1,  5'd5,  3'b001, 1'b1, 5,  6,  5,   5,   5,   9,  0, 0};
    vecs[5] = '{8'd60, 7'd3,  5'd3,  5'd3,  3'b100, 1'b1, 8,  10, 60,  3,   62,  5,  0, 0};
    vecs[6] = '{8'd1,  7'd2,  5'd5,  5'd0,  3'b011, 1'b0, 0,  1,  0,   0,   0,   0,  0, 0};
    vecs[7] = '{8'd10, 7'd20, 5'd4,  5'd3,  3'b110, 1'b0, 12, 13, 10,  20,  13,  22, 1, 0};

    reset_n = 1'b0; start = 1'b0; abort = 1'b0;
    x0 = '0; y0 = '0; width = '0; height = '0; colour_in = '0; mode = 1'b0;
    step();
    step();
    check("rst x", int'(x), 0);
    check("rst y", int'(y), 0);
    check("rst colour", int'(colour), 0);
    check("rst plot", int'(plot), 0);
    check("rst busy", int'(busy), 0);
    check("rst done", int'(done), 0);
    reset_n = 1'b1;
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("idle_abort busy", int'(busy), 0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Abort while pixel 5 of a 16x16 fill is presented.
    x0 = 8'd0; y0 = 7'd0; width = 5'd16; height = 5'd16;
    colour_in = 3'b001; mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k < 7; k++) step();
    check("abort px5 x", int'(x), 5);
    check("abort px5 plot", int'(plot), 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort plot", int'(plot), 0);
    check("abort busy", int'(busy), 0);
    check("abort done", int'(done), 0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("abort quiet done", int'(done), 0);
      check("abort quiet busy", int'(busy), 0);
    end
    run_vec(vecs[0], 10);

    // Reset mid-DRAW clears every output with no done pulse.
    x0 = 8'd100; y0 = 7'd50; width = 5'd16; height = 5'd16;
    colour_in = 3'b110; mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k < 5; k++) step();
    check("rstmid pre busy", int'(busy), 1);
    reset_n = 1'b0;
    step();
    check("rstmid x", int'(x), 0);
    check("rstmid y", int'(y), 0);
    check("rstmid colour", int'(colour), 0);
    check("rstmid plot", int'(plot), 0);
    check("rstmid busy", int'(busy), 0);
    check("rstmid done", int'(done), 0);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("rstmid quiet done", int'(done), 0);
    end

    // start and abort together in IDLE: start wins, 2x2 fill completes.
    begin
      int done_k;
      x0 = 8'd3; y0 = 7'd3; width = 5'd2; height = 5'd2;
      colour_in = 3'b010; mode = 1'b0; start = 1'b1; abort = 1'b1;
      step();
      start = 1'b0; abort = 1'b0;
      check("start_abort busy", int'(busy), 1);
      done_k = -1;
      for (int k = 1; k < 50 && done_k < 0; k++) begin
        if (done) done_k = k;
        else step();
      end
      check("start_abort done_latency", done_k, 6);
    end

    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
